// File: rtl/calc_pkg.sv
// Shared types, constants and helpers for the calculator keypad entry path.
package calc_pkg;

  localparam int unsigned DIGIT_W        = 4;
  localparam int unsigned BCD_MAX_DIGITS = 8;
  localparam int unsigned BCD_MAX_W      = DIGIT_W * BCD_MAX_DIGITS;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  // One action per cycle, picked by key priority.
  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_CLR  = 3'd1,
    ACT_BKSP = 3'd2,
    ACT_SIGN = 3'd3,
    ACT_EQ   = 3'd4,
    ACT_OP   = 3'd5,
    ACT_DIG  = 3'd6
  } act_t;

  typedef struct packed {
    logic clear;
    logic load;
    logic pop;
    logic push;
  } opnd_cmd_t;

  // Number of significant BCD digits; zero has length 0.
  function automatic logic [3:0] bcd_len(input logic [BCD_MAX_W-1:0] value);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < int'(BCD_MAX_DIGITS); i++) begin
      if (value[i*DIGIT_W +: DIGIT_W] != '0) n = 4'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/operand_reg.sv
// BCD operand shift register with length tracking; clear > load > pop > push.
module operand_reg
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned LEN_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  opnd_cmd_t                     cmd,
  input  logic [DIGIT_W-1:0]            din,
  input  logic [DIGIT_W*MAX_DIGITS-1:0] load_val,
  output logic [DIGIT_W*MAX_DIGITS-1:0] value,
  output logic [LEN_W-1:0]              len,
  output logic                          full_c,
  output logic                          empty_c
);

  localparam int unsigned W = DIGIT_W * MAX_DIGITS;

  always_ff @(posedge clock) begin
    if (reset || cmd.clear) begin
      value <= '0;
      len   <= '0;
    end else if (cmd.load) begin
      value <= load_val;
      len   <= LEN_W'(bcd_len(BCD_MAX_W'(load_val)));
    end else if (cmd.pop) begin
      value <= value >> DIGIT_W;
      len   <= len - LEN_W'(1);
    end else if (cmd.push) begin
      value <= (value << DIGIT_W) | W'(din);
      // Leading zeros keep the operand empty.
      if (!(len == '0 && din == '0)) len <= len + LEN_W'(1);
    end
  end

  assign full_c  = (len == LEN_W'(MAX_DIGITS));
  assign empty_c = (len == '0);

endmodule

// File: rtl/entry_ctrl.sv
// Keypad entry controller: builds BCD operands A/B and drives the ALU req/ack handshake.
// Optional signed entry is enabled by defining ENTRY_SIGN_EN.
module entry_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned LEN_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          dig_in,
  input  logic [3:0]                    digit,
  input  logic                          op_in,
  input  logic [1:0]                    op_code,
  input  logic                          bksp_in,
  input  logic                          eq_in,
  input  logic                          clr_in,
  input  logic                          exec_ack,
  input  logic [4*MAX_DIGITS-1:0]       result,
  output logic [4*MAX_DIGITS-1:0]       operand_a,
  output logic [4*MAX_DIGITS-1:0]       operand_b,
  output logic [LEN_W-1:0]              len_a,
  output logic [LEN_W-1:0]              len_b,
  output logic [1:0]                    op_sel,
  output logic                          active_b,
  output logic                          exec_req,
  output logic                          err
`ifdef ENTRY_SIGN_EN
  ,
  input  logic                          sign_in,
  input  logic                          result_sign,
  output logic                          sign_a,
  output logic                          sign_b
`endif
);

  state_t    state, next_state;
  act_t      act;
  opnd_cmd_t cmd_a, cmd_b;
  logic      full_a, empty_a, full_b, empty_b;
  logic      edit_b, edit_full, edit_empty;
  logic [1:0] op_sel_d, pend_op, pend_op_d;
  logic      chain, chain_d;
  logic      exec_req_d, err_d, active_b_d;
`ifdef ENTRY_SIGN_EN
  logic      sign_a_d, sign_b_d;
`endif

  operand_reg #(.MAX_DIGITS(MAX_DIGITS), .LEN_W(LEN_W)) u_opnd_a (
    .clock    (clock),
    .reset    (reset),
    .cmd      (cmd_a),
    .din      (digit),
    .load_val (result),
    .value    (operand_a),
    .len      (len_a),
    .full_c   (full_a),
    .empty_c  (empty_a)
  );

  operand_reg #(.MAX_DIGITS(MAX_DIGITS), .LEN_W(LEN_W)) u_opnd_b (
    .clock    (clock),
    .reset    (reset),
    .cmd      (cmd_b),
    .din      (digit),
    .load_val (result),
    .value    (operand_b),
    .len      (len_b),
    .full_c   (full_b),
    .empty_c  (empty_b)
  );

  // Key priority decode: lower-priority pulses in the same cycle are dropped.
  always_comb begin
    act = ACT_NONE;
    if (clr_in)        act = ACT_CLR;
    else if (bksp_in)  act = ACT_BKSP;
`ifdef ENTRY_SIGN_EN
    else if (sign_in)  act = ACT_SIGN;
`endif
    else if (eq_in)    act = ACT_EQ;
    else if (op_in)    act = ACT_OP;
    else if (dig_in)   act = ACT_DIG;
  end

  assign edit_b     = (state == S_B);
  assign edit_full  = edit_b ? full_b  : full_a;
  assign edit_empty = edit_b ? empty_b : empty_a;

  always_ff @(posedge clock) begin
    if (reset) state <= S_A;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_A:     if (act == ACT_OP) next_state = S_B;
      S_B:     if ((act == ACT_EQ || act == ACT_OP) && !empty_b) next_state = S_EXEC;
      S_EXEC:  if (exec_ack) next_state = chain ? S_B : S_A;
      default: next_state = S_A;
    endcase
    if (act == ACT_CLR) next_state = S_A;
  end

  // Operand commands and next values of the registered outputs.
  always_comb begin
    cmd_a     = '0;
    cmd_b     = '0;
    err_d     = 1'b0;
    op_sel_d  = op_sel;
    pend_op_d = pend_op;
    chain_d   = chain;
`ifdef ENTRY_SIGN_EN
    sign_a_d  = sign_a;
    sign_b_d  = sign_b;
`endif
    if (act == ACT_CLR) begin
      cmd_a.clear = 1'b1;
      cmd_b.clear = 1'b1;
      op_sel_d    = OP_ADD;
      pend_op_d   = OP_ADD;
      chain_d     = 1'b0;
`ifdef ENTRY_SIGN_EN
      sign_a_d    = 1'b0;
      sign_b_d    = 1'b0;
`endif
    end else if (state == S_EXEC) begin
      if (exec_ack) begin
        cmd_a.load  = 1'b1;
        cmd_b.clear = 1'b1;
        chain_d     = 1'b0;
        if (chain) op_sel_d = pend_op;
`ifdef ENTRY_SIGN_EN
        sign_a_d    = result_sign;
        sign_b_d    = 1'b0;
`endif
      end
    end else begin
      unique case (act)
        ACT_BKSP: begin
          if (edit_empty)  err_d = 1'b1;
          else if (edit_b) cmd_b.pop = 1'b1;
          else             cmd_a.pop = 1'b1;
        end
`ifdef ENTRY_SIGN_EN
        ACT_SIGN: begin
          if (edit_b) sign_b_d = ~sign_b;
          else        sign_a_d = ~sign_a;
        end
`endif
        ACT_EQ: begin
          if (!edit_b || empty_b) err_d = 1'b1;
          else                    chain_d = 1'b0;
        end
        ACT_OP: begin
          if (!edit_b || empty_b) begin
            op_sel_d = op_code;
          end else begin
            pend_op_d = op_code;
            chain_d   = 1'b1;
          end
        end
        ACT_DIG: begin
          if (edit_full || digit > 4'd9) err_d = 1'b1;
          else if (edit_b)               cmd_b.push = 1'b1;
          else                           cmd_a.push = 1'b1;
        end
        default: ;
      endcase
    end
    exec_req_d = (next_state == S_EXEC);
    active_b_d = (next_state == S_B);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_sel   <= OP_ADD;
      pend_op  <= OP_ADD;
      chain    <= 1'b0;
      exec_req <= 1'b0;
      active_b <= 1'b0;
      err      <= 1'b0;
`ifdef ENTRY_SIGN_EN
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
`endif
    end else begin
      op_sel   <= op_sel_d;
      pend_op  <= pend_op_d;
      chain    <= chain_d;
      exec_req <= exec_req_d;
      active_b <= active_b_d;
      err      <= err_d;
`ifdef ENTRY_SIGN_EN
      sign_a   <= sign_a_d;
      sign_b   <= sign_b_d;
`endif
    end
  end

endmodule

// File: tb/tb_entry_ctrl.sv
// Scoreboard bench for entry_ctrl: directed key sequences queue expected snapshots, a monitor checks them.
module tb_entry_ctrl;

  localparam int unsigned MAXD = 4;
  localparam int unsigned W    = 4 * MAXD;
  localparam int unsigned LW   = $clog2(MAXD + 1);

  logic          clock;
  logic          reset;
  logic          dig_in;
  logic [3:0]    digit;
  logic          op_in;
  logic [1:0]    op_code;
  logic          bksp_in;
  logic          eq_in;
  logic          clr_in;
  logic          exec_ack;
  logic [W-1:0]  result;
  logic [W-1:0]  operand_a, operand_b;
  logic [LW-1:0] len_a, len_b;
  logic [1:0]    op_sel;
  logic          active_b, exec_req, err;

  entry_ctrl #(.MAX_DIGITS(MAXD)) dut (
    .clock     (clock),
    .reset     (reset),
    .dig_in    (dig_in),
    .digit     (digit),
    .op_in     (op_in),
    .op_code   (op_code),
    .bksp_in   (bksp_in),
    .eq_in     (eq_in),
    .clr_in    (clr_in),
    .exec_ack  (exec_ack),
    .result    (result),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .len_a     (len_a),
    .len_b     (len_b),
    .op_sel    (op_sel),
    .active_b  (active_b),
    .exec_req  (exec_req),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int            due;
    string         name;
    logic [W-1:0]  a, b;
    logic [LW-1:0] la, lb;
    logic [1:0]    op;
    logic          ab, req, er;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: compares the snapshot due in the current cycle, away from the edge.
  always @(negedge clock) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: check was skipped (due cycle %0d, now %0d)", e.name, e.due, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({operand_a, operand_b, len_a, len_b, op_sel, active_b, exec_req, err} !==
          {e.a, e.b, e.la, e.lb, e.op, e.ab, e.req, e.er}) begin
        n_bad++;
        $display("FAIL %s: got a=%h b=%h la=%0d lb=%0d op=%0d ab=%b req=%b err=%b, want a=%h b=%h la=%0d lb=%0d op=%0d ab=%b req=%b err=%b",
                 e.name, operand_a, operand_b, len_a, len_b, op_sel, active_b, exec_req, err,
                 e.a, e.b, e.la, e.lb, e.op, e.ab, e.req, e.er);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    reset    = 1'b0;
    dig_in   = 1'b0;
    op_in    = 1'b0;
    bksp_in  = 1'b0;
    eq_in    = 1'b0;
    clr_in   = 1'b0;
    exec_ack = 1'b0;
  endtask

  task automatic expect_st(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [LW-1:0] la, input logic [LW-1:0] lb, input logic [1:0] op,
                           input logic ab, input logic req, input logic er);
    exp_t e;
    e.due = cyc; e.name = name;
    e.a = a; e.b = b; e.la = la; e.lb = lb; e.op = op; e.ab = ab; e.req = req; e.er = er;
    exp_q.push_back(e);
  endtask

  task automatic press_dig(input logic [3:0] d);
    dig_in = 1'b1;
    digit  = d;
    tick();
  endtask

  task automatic press_op(input logic [1:0] c);
    op_in   = 1'b1;
    op_code = c;
    tick();
  endtask

  task automatic ack(input logic [W-1:0] r);
    exec_ack = 1'b1;
    result   = r;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time bound at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; dig_in = 1'b0; digit = '0; op_in = 1'b0; op_code = '0;
    bksp_in = 1'b0; eq_in = 1'b0; clr_in = 1'b0; exec_ack = 1'b0; result = '0;
    tick();
    expect_st("reset", 16'h0, 16'h0, 0, 0, 0, 0, 0, 0);

    // Digit entry and backspace
    press_dig(4'd1); expect_st("dig1", 16'h1, 16'h0, 1, 0, 0, 0, 0, 0);
    press_dig(4'd2); expect_st("dig2", 16'h12, 16'h0, 2, 0, 0, 0, 0, 0);
    press_dig(4'd3); expect_st("dig3", 16'h123, 16'h0, 3, 0, 0, 0, 0, 0);
    bksp_in = 1'b1; tick(); expect_st("bksp", 16'h12, 16'h0, 2, 0, 0, 0, 0, 0);

    // Full operand and invalid digit
    clr_in = 1'b1; tick(); expect_st("clr1", 16'h0, 16'h0, 0, 0, 0, 0, 0, 0);
    press_dig(4'd9); press_dig(4'd8); press_dig(4'd7);
    press_dig(4'd6); expect_st("fill", 16'h9876, 16'h0, 4, 0, 0, 0, 0, 0);
    press_dig(4'd5); expect_st("full_rej", 16'h9876, 16'h0, 4, 0, 0, 0, 0, 1);
    tick();          expect_st("err_1cyc", 16'h9876, 16'h0, 4, 0, 0, 0, 0, 0);
    clr_in = 1'b1; tick();
    press_dig(4'hA); expect_st("bad_digit", 16'h0, 16'h0, 0, 0, 0, 0, 0, 1);
    press_dig(4'd0); expect_st("lead_zero", 16'h0, 16'h0, 0, 0, 0, 0, 0, 0);

    // 12 + 3 with a delayed ack
    press_dig(4'd1); press_dig(4'd2);
    press_op(2'd0);  expect_st("op_add", 16'h12, 16'h0, 2, 0, 0, 1, 0, 0);
    press_dig(4'd3); expect_st("b_dig3", 16'h12, 16'h3, 2, 1, 0, 1, 0, 0);
    eq_in = 1'b1; tick(); expect_st("eq_req", 16'h12, 16'h3, 2, 1, 0, 0, 1, 0);
    tick();          expect_st("wait1", 16'h12, 16'h3, 2, 1, 0, 0, 1, 0);
    press_dig(4'd7); expect_st("exec_ignore", 16'h12, 16'h3, 2, 1, 0, 0, 1, 0);
    tick();          expect_st("wait3", 16'h12, 16'h3, 2, 1, 0, 0, 1, 0);
    ack(16'h15);     expect_st("ack_15", 16'h15, 16'h0, 2, 0, 0, 0, 0, 0);

    // Chaining: 5 * 2 then '-'
    clr_in = 1'b1; tick();
    press_dig(4'd5);
    press_op(2'd2);  expect_st("op_mul", 16'h5, 16'h0, 1, 0, 2, 1, 0, 0);
    press_dig(4'd2);
    press_op(2'd1);  expect_st("chain_req", 16'h5, 16'h2, 1, 1, 2, 0, 1, 0);
    ack(16'h10);     expect_st("chain_ack", 16'h10, 16'h0, 2, 0, 1, 1, 0, 0);
    press_op(2'd3);  expect_st("op_replace", 16'h10, 16'h0, 2, 0, 3, 1, 0, 0);
    eq_in = 1'b1; tick(); expect_st("eq_b_empty", 16'h10, 16'h0, 2, 0, 3, 1, 0, 1);

    // Clear with a digit while waiting on the ALU; late ack must be ignored
    press_dig(4'd4); expect_st("b_dig4", 16'h10, 16'h4, 2, 1, 3, 1, 0, 0);
    eq_in = 1'b1; tick(); expect_st("eq_req2", 16'h10, 16'h4, 2, 1, 3, 0, 1, 0);
    clr_in = 1'b1; dig_in = 1'b1; digit = 4'd7; tick();
    expect_st("clr_exec", 16'h0, 16'h0, 0, 0, 0, 0, 0, 0);
    ack(16'h99);     expect_st("stray_ack", 16'h0, 16'h0, 0, 0, 0, 0, 0, 0);

    // Rejections with no state change
    eq_in = 1'b1; tick();   expect_st("eq_in_a", 16'h0, 16'h0, 0, 0, 0, 0, 0, 1);
    bksp_in = 1'b1; tick(); expect_st("bksp_empty", 16'h0, 16'h0, 0, 0, 0, 0, 0, 1);
    tick();                 expect_st("err_clear", 16'h0, 16'h0, 0, 0, 0, 0, 0, 0);

    // Backspace outranks a simultaneous digit
    press_dig(4'd3); expect_st("dig3b", 16'h3, 16'h0, 1, 0, 0, 0, 0, 0);
    bksp_in = 1'b1; dig_in = 1'b1; digit = 4'd7; tick();
    expect_st("bksp_prio", 16'h0, 16'h0, 0, 0, 0, 0, 0, 0);

    tick();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected snapshots never checked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
